// File: rtl/dc_pkg.sv
// -----------------------------------------------------------------------------
// dc_pkg
// Shared types and helpers for the read side of the dual-clock buffer slice.
//   - out_state_e     : output-stage state (empty / holding an entry)
//   - dc_vec_t        : widest one-hot pointer the helpers accept
//   - DC_PTR_RESET    : one-hot pointer reset value (slot 0)
//   - onehot_rotl()   : rotate a one-hot pointer left within 'depth' bits
//   - onehot_is_legal(): true when exactly one bit is set
// Callers zero-extend their pointer to dc_vec_t and truncate the result back.
// -----------------------------------------------------------------------------
package dc_pkg;

  localparam int DC_MAX_DEPTH = 64;

  typedef logic [DC_MAX_DEPTH-1:0] dc_vec_t;

  localparam dc_vec_t DC_PTR_RESET = dc_vec_t'(1);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Rotate left by one inside the low 'depth' bits; bit depth-1 wraps to bit 0.
  function automatic dc_vec_t onehot_rotl(input dc_vec_t vec, input int depth);
    dc_vec_t rot;
    rot = '0;
    for (int i = 1; i < DC_MAX_DEPTH; i++) begin
      if (i < depth) rot[i] = vec[i-1];
    end
    for (int i = 0; i < DC_MAX_DEPTH; i++) begin
      if (i == depth - 1) rot[0] = vec[i];
    end
    return rot;
  endfunction

  function automatic logic onehot_is_legal(input dc_vec_t vec);
    return $countones(vec) == 1;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// -----------------------------------------------------------------------------
// onehot_to_bin
// Converts a one-hot vector to the binary index of its set bit. An illegal
// input yields the OR of the indices of all set bits.
//   onehot_i : WIDTH-bit one-hot input
//   bin_o    : $clog2(WIDTH)-bit binary index
// -----------------------------------------------------------------------------
module onehot_to_bin #(
  parameter int WIDTH     = 8,
  parameter int BIN_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     onehot_i,
  output logic [BIN_WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_i[i]) bin_o = bin_o | BIN_WIDTH'(i);
    end
  end

endmodule

// File: rtl/dc_read_controller.sv
// -----------------------------------------------------------------------------
// dc_read_controller
// Read-domain controller for the one-hot-pointer data buffer. Owns the one-hot
// read pointer, compares it with the already-synchronised write token, and
// pops entries into a one-entry registered valid/ready output stage.
//
// Ports
//   clk          : read-domain clock
//   rst          : synchronous active-high reset
//   write_token  : one-hot write pointer (synchronised into clk)
//   read_pointer : one-hot read pointer to the buffer read port
//   read_data    : buffer data at read_pointer (combinational)
//   data_out     : registered output data
//   valid_out    : data_out holds a valid entry
//   ready_in     : consumer accepts data_out
//   token_error  : sticky, write_token was seen not one-hot
//   occupancy    : entries left in the buffer (only with
//                  DC_READ_CTRL_OCCUPANCY_EN defined)
//
// Build option: define DC_READ_CTRL_OCCUPANCY_EN to add the occupancy output.
// BUFFER_DEPTH must be in 2..dc_pkg::DC_MAX_DEPTH.
// -----------------------------------------------------------------------------
module dc_read_controller
  import dc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUFFER_DEPTH-1:0]   write_token,
  output logic [BUFFER_DEPTH-1:0]   read_pointer,
  input  logic [DATA_WIDTH-1:0]     read_data,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      token_error
`ifdef DC_READ_CTRL_OCCUPANCY_EN
  ,
  output logic [$clog2(BUFFER_DEPTH)-1:0] occupancy
`endif
);

  out_state_e              state_q, state_d;
  logic [BUFFER_DEPTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;

  logic token_legal;
  logic buf_empty;
  logic load;

  // An illegal token cannot be compared meaningfully, so treat it as empty.
  assign token_legal = onehot_is_legal(dc_vec_t'(write_token));
  assign buf_empty   = !token_legal || (ptr_q == write_token);
  // valid_out comes from state_q only; ready_in just lets a new entry replace
  // the one being accepted in the same cycle.
  assign load        = !buf_empty && ((state_q == OUT_EMPTY) || ready_in);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    err_d   = err_q | !token_legal;

    case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL: begin
        if (load)          state_d = OUT_FULL;
        else if (ready_in) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase

    if (load) begin
      data_d = read_data;
      ptr_d  = BUFFER_DEPTH'(onehot_rotl(dc_vec_t'(ptr_q), BUFFER_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= OUT_EMPTY;
      ptr_q   <= BUFFER_DEPTH'(DC_PTR_RESET);
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign read_pointer = ptr_q;
  assign data_out     = data_q;
  assign valid_out    = (state_q == OUT_FULL);
  assign token_error  = err_q;

`ifdef DC_READ_CTRL_OCCUPANCY_EN
  localparam int PTR_BITS = $clog2(BUFFER_DEPTH);

  logic [PTR_BITS-1:0] wr_bin, rd_bin, occ_d, occ_q;

  onehot_to_bin #(.WIDTH(BUFFER_DEPTH)) u_wr_bin (
    .onehot_i (write_token),
    .bin_o    (wr_bin)
  );

  onehot_to_bin #(.WIDTH(BUFFER_DEPTH)) u_rd_bin (
    .onehot_i (ptr_q),
    .bin_o    (rd_bin)
  );

  // Explicit wrap so non-power-of-two depths still reduce modulo BUFFER_DEPTH.
  always_comb begin
    if (wr_bin >= rd_bin) occ_d = wr_bin - rd_bin;
    else                  occ_d = PTR_BITS'(BUFFER_DEPTH + int'(wr_bin) - int'(rd_bin));
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: doc/dc_read_controller.md
Name: dc_read_controller

Overview:
- Read-side controller for the one-hot-pointer data buffer in the dual-clock slice.
- Owns the one-hot read pointer and compares it with the write token, which has already been synchronised into this clock domain.
- Pops entries through a one-entry registered output stage that speaks valid/ready to the downstream consumer.
- Single-clock block; lives entirely in the read domain.

Parameters:
- DATA_WIDTH, 32, width of a buffer entry and of data_out.
- BUFFER_DEPTH, 8, number of buffer slots and width of the one-hot pointers; must be >= 2.

Ports:
- clk  input  1  read-domain clock.
- rst  input  1  reset: synchronous, active-high.
- write_token  input  BUFFER_DEPTH  one-hot write pointer, already synchronised into clk domain.
- read_pointer  output  BUFFER_DEPTH  one-hot read pointer driven to the buffer read port.
- read_data  input  DATA_WIDTH  buffer data at read_pointer (combinational from buffer).
- data_out  output  DATA_WIDTH  registered output data.
- valid_out  output  1  data_out holds a valid entry.
- ready_in  input  1  consumer accepts data_out.
- token_error  output  1  sticky flag: write_token was seen not one-hot.

Behaviour:
- Reset (rst=1 at posedge): read_pointer=1 (bit 0 set), data_out=0, valid_out=0, token_error=0.
- Reset mid-operation discards any held entry; the writer side is reset by the same system reset.
- buf_empty is asserted when read_pointer == write_token.
  - The writer keeps one slot free, so at most BUFFER_DEPTH-1 entries are outstanding.
  - "Full" is never decoded here.
- load = !buf_empty && (!valid_out || ready_in).
- On load, at posedge:
  - data_out <= read_data.
  - valid_out <= 1.
  - read_pointer rotates left by one; MSB wraps to bit 0.
- Else if valid_out && ready_in: valid_out <= 0 and data_out holds its value.
- Else all registers hold.
- data_out and valid_out hold stable while valid_out=1 and ready_in=0 (AXI-style rule). valid_out never depends combinationally on ready_in.
- Simultaneous pop and load (valid_out=1, ready_in=1, buffer non-empty) gives back-to-back transfers, one entry per cycle.
- Latency: write_token advances in cycle N → valid_out=1 in cycle N+1 (output stage empty).
- Throughput: 1 entry/clk sustained.
- token_error is set at posedge when write_token has popcount != 1, and clears only on rst.
  - While write_token is illegal, buf_empty is forced to 1, so no load occurs.
- Two-state FSM, implicit in valid_out:
  - OUT_EMPTY → OUT_FULL on load.
  - OUT_FULL → OUT_FULL on load with ready_in.
  - OUT_FULL → OUT_EMPTY on ready_in without load.

Optional Feature:
- Macro DC_READ_CTRL_OCCUPANCY_EN.
- When defined, adds output occupancy [$clog2(BUFFER_DEPTH)-1:0]:
  - Value is (bin(write_token) - bin(read_pointer)) mod BUFFER_DEPTH, i.e. entries still in the buffer, excluding the output stage.
  - Registered; reset value 0; updated every cycle one clk after pointer changes.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package dc_pkg:
  - function onehot_rotl (one-hot rotate left).
  - function onehot_is_legal (popcount == 1).
  - localparam for pointer reset value.
- Sub-module: the existing onehot_to_bin, instantiated twice, only under DC_READ_CTRL_OCCUPANCY_EN.
- No other sub-modules.

Test Plan:
- Reset then idle with write_token=8'h01 → read_pointer=8'h01, valid_out=0 for 10 cycles, token_error=0.
- write_token 8'h01→8'h02 in cycle N, read_data=32'hDEADBEEF, ready_in=1 → valid_out=1 and data_out=32'hDEADBEEF in N+1; read_pointer=8'h02; valid_out=0 in N+2.
- Buffer holds 7 entries (write_token=8'h80, read_pointer=8'h01), ready_in=1 constant → 7 consecutive valid beats; read_pointer wraps 8'h80→8'h01 only after the write token wraps; occupancy (macro on) counts 7→0.
- Backpressure: valid_out=1, ready_in=0 for 5 cycles with 3 entries pending → data_out stable, read_pointer unchanged; ready_in=1 → 3 further back-to-back beats.
- write_token=8'h03 for one cycle → token_error=1 sticky, no load that cycle; rst=1 → token_error=0.
- rst asserted while valid_out=1 → next cycle valid_out=0, data_out=0, read_pointer=8'h01.
